// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Holds the op and FSM state encodings and the default datapath width.
package mult_div_unit_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } md_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_datapath.sv
// Shift-register datapath for the iterative multiply/divide unit.
// One shared adder performs either a shift-add or a restoring-divide step each cycle.
module md_datapath
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_val,
    input  logic [WIDTH-1:0] b_val,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH:0]     lhs;
    logic [WIDTH:0]     rhs;
    logic [WIDTH+1:0]   sum;

    assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_q[WIDTH-1:0];

    // Divide computes {rem,next dividend bit} - divisor; sum MSB set means no borrow.
    always_comb begin
        lhs = is_div ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
        if (is_div) begin
            rhs = ~{1'b0, opnd_q};
        end else begin
            rhs = acc_lo[0] ? {1'b0, opnd_q} : '0;
        end
        sum = {1'b0, lhs} + {1'b0, rhs} + (WIDTH+2)'(is_div);

        if (!is_div) begin
            acc_step = {sum[WIDTH:0], acc_lo[WIDTH-1:1]};
        end else if (sum[WIDTH+1]) begin
            acc_step = {sum[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {lhs[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Multiply: low word holds the multiplier, opnd_q the multiplicand.
    // Divide: low word holds the dividend, opnd_q the divisor.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else if (load) begin
            acc_q  <= {{WIDTH{1'b0}}, is_div ? a_val : b_val};
            opnd_q <= is_div ? b_val : a_val;
        end else if (step) begin
            acc_q  <= acc_step;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: FSM, iteration counter, sign fix-up and HI/LO.
// MULT/DIV results appear WIDTH+1 cycles after issue; MTHI/MTLO write on the issue edge.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             is_div_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] rs_raw_q;

    logic             idle_accept;
    logic             md_issue;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] abs_rs;
    logic [WIDTH-1:0] abs_rt;
    logic             dp_is_div;
    logic             dp_step;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign busy = busy_q;
    // A flush arriving in FIX cancels the write, so the pulse must be withdrawn too.
    assign done = done_q & ~flush;
    assign HI   = hi_q;
    assign LO   = lo_q;

    assign idle_accept = (state == S_IDLE) && start && !flush;
    assign md_issue    = idle_accept && !op[2];

    assign rs_neg = is_signed_op(op) && rs_val[WIDTH-1];
    assign rt_neg = is_signed_op(op) && rt_val[WIDTH-1];
    assign abs_rs = rs_neg ? -rs_val : rs_val;
    assign abs_rt = rt_neg ? -rt_val : rt_val;

    assign dp_is_div = (state == S_IDLE) ? is_div_op(op) : is_div_q;
    assign dp_step   = (state == S_CALC) && !flush;

    md_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .CLK    (CLK),
        .RST    (RST),
        .load   (md_issue),
        .step   (dp_step),
        .is_div (dp_is_div),
        .a_val  (abs_rs),
        .b_val  (abs_rt),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    always_comb begin
        prod = {acc_hi, acc_lo};
        if (neg_q) begin
            prod = -prod;
        end
        quo = neg_q ? -acc_lo : acc_lo;
        rem = rem_neg_q ? -acc_hi : acc_hi;

        if (!is_div_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (div_zero_q) begin
            res_hi = rs_raw_q;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= S_IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            rs_raw_q   <= '0;
        end else if (flush) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi_q <= rs_val;
                            OP_MTLO: lo_q <= rs_val;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state      <= S_CALC;
                                cnt        <= '0;
                                busy_q     <= 1'b1;
                                is_div_q   <= is_div_op(op);
                                neg_q      <= rs_neg ^ rt_neg;
                                rem_neg_q  <= rs_neg;
                                div_zero_q <= (rt_val == '0);
                                rs_raw_q   <= rs_val;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (cnt == CNT_LAST) begin
                        state  <= S_FIX;
                        cnt    <= '0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus a randomized op stream
// compared against a plain-arithmetic HI/LO reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  rs_val = '0;
    logic [W-1:0]  rt_val = '0;
    logic          flush = 1'b0;
    logic          busy;
    logic          done;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(
        .WIDTH (W)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 CLK = ~CLK;

    // Reference: architectural result of one MULT/MULTU/DIV/DIVU.
    function automatic void ref_md(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] h,
                                   output logic [31:0] l);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] r64;
        logic [63:0] q64;
        h = '0;
        l = '0;
        case (o)
            3'd0: begin
                r64 = 64'(sa * sb);
                {h, l} = r64;
            end
            3'd1: begin
                r64 = {32'b0, a} * {32'b0, b};
                {h, l} = r64;
            end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (o == 3'd2) begin
                    q64 = 64'(sa / sb);
                    r64 = 64'(sa % sb);
                    l = q64[31:0];
                    h = r64[31:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    // Issue one MULT/DIV-class op and observe busy/done over the following cycles.
    task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n, output int done_n, output int done_at);
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        @(negedge CLK);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 1; i <= W + 6; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = i;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        int bn, dn, da;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests++;
        if ({HI, LO, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got HI=%h LO=%h busy=%b done=%b, required all 0",
                     HI, LO, busy, done);
        end
        RST = 1'b1;
        run_md(3'd1, 32'h0000_1234, 32'h0001_0000, bn, dn, da);
        n_tests++;
        if (HI !== 32'h0 || LO !== 32'h1234_0000) begin
            n_fail++;
            $display("FAIL reset_premult: got HI=%h LO=%h, required 00000000 12340000", HI, LO);
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests++;
        if ({HI, LO, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_clear: got HI=%h LO=%h busy=%b done=%b, required all 0",
                     HI, LO, busy, done);
        end
        RST = 1'b1;
        // Reset in the middle of an operation aborts it.
        @(negedge CLK);
        start = 1'b1; op = 3'd0; rs_val = 32'd9; rt_val = 32'd9;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        repeat (W + 4) @(negedge CLK);
        n_tests++;
        if ({HI, LO, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_midop: got HI=%h LO=%h busy=%b, required all 0", HI, LO, busy);
        end
    endtask

    task automatic test_mult_timing;
        int bn, dn, da;
        run_md(3'd0, 32'hFFFF_FFFD, 32'd5, bn, dn, da);
        n_tests++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFF1) begin
            n_fail++;
            $display("FAIL mult_neg3x5: got HI=%h LO=%h, required ffffffff fffffff1", HI, LO);
        end
        n_tests++;
        if (bn !== W + 1) begin
            n_fail++;
            $display("FAIL busy_cycles: got %0d, required %0d", bn, W + 1);
        end
        n_tests++;
        if (dn !== 1 || da !== W + 1) begin
            n_fail++;
            $display("FAIL done_pulse: got count %0d at cycle %0d, required 1 at %0d",
                     dn, da, W + 1);
        end
    endtask

    task automatic test_multu_divu;
        int bn, dn, da;
        run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn, dn, da);
        n_tests++;
        if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_max: got HI=%h LO=%h, required fffffffe 00000001", HI, LO);
        end
        run_md(3'd3, 32'd100, 32'd7, bn, dn, da);
        n_tests++;
        if (HI !== 32'd2 || LO !== 32'd14) begin
            n_fail++;
            $display("FAIL divu_100_7: got HI=%h LO=%h, required 00000002 0000000e", HI, LO);
        end
    endtask

    task automatic test_div_signed;
        int bn, dn, da;
        run_md(3'd2, 32'hFFFF_FFF9, 32'd2, bn, dn, da);
        n_tests++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_m7_2: got HI=%h LO=%h, required ffffffff fffffffd", HI, LO);
        end
        run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bn, dn, da);
        n_tests++;
        if (HI !== 32'h0 || LO !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_overflow: got HI=%h LO=%h, required 00000000 80000000", HI, LO);
        end
    endtask

    task automatic test_div_zero;
        int bn, dn, da;
        for (int s = 0; s < 2; s++) begin
            run_md(s == 0 ? 3'd2 : 3'd3, 32'h1234_5678, 32'h0, bn, dn, da);
            n_tests++;
            if (HI !== 32'h1234_5678 || LO !== 32'hFFFF_FFFF || da !== W + 1) begin
                n_fail++;
                $display("FAIL div_zero_%0d: got HI=%h LO=%h done@%0d, required 12345678 ffffffff @%0d",
                         s, HI, LO, da, W + 1);
            end
        end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge CLK);
        start = 1'b1; op = 3'd4; rs_val = 32'hAAAA_5555;
        @(negedge CLK);
        n_tests++;
        if (HI !== 32'hAAAA_5555 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi: got HI=%h busy=%b done=%b, required aaaa5555 0 0", HI, busy, done);
        end
        op = 3'd5; rs_val = 32'h0F0F_0F0F;
        @(negedge CLK);
        start = 1'b0;
        n_tests++;
        if (LO !== 32'h0F0F_0F0F || HI !== 32'hAAAA_5555 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo: got HI=%h LO=%h busy=%b done=%b, required aaaa5555 0f0f0f0f 0 0",
                     HI, LO, busy, done);
        end
        // Flush together with start in IDLE: nothing accepted.
        start = 1'b1; flush = 1'b1; op = 3'd4; rs_val = 32'h1111_2222;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        n_tests++;
        if (HI !== 32'hAAAA_5555 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_flush_start: got HI=%h busy=%b, required aaaa5555 0", HI, busy);
        end
    endtask

    task automatic test_flush;
        logic [31:0] prev_hi, prev_lo;
        int bn, dn, da;
        int done_seen = 0;
        prev_hi = HI;
        prev_lo = LO;
        @(negedge CLK);
        start = 1'b1; op = 3'd0; rs_val = 32'd6; rt_val = 32'd7;
        @(negedge CLK);
        start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (done) done_seen++;
            if (k == 5) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_in_calc: got %b, required 1", busy);
                end
                start = 1'b1; op = 3'd4; rs_val = 32'hDEAD_BEEF;
            end
            if (k == 6) start = 1'b0;
            if (k == 10) flush = 1'b1;
            @(negedge CLK);
        end
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || HI !== prev_hi || LO !== prev_lo) begin
            n_fail++;
            $display("FAIL flush_abort: got busy=%b HI=%h LO=%h, required 0 %h %h",
                     busy, HI, LO, prev_hi, prev_lo);
        end
        for (int k = 0; k < W + 4; k++) begin
            if (done) done_seen++;
            @(negedge CLK);
        end
        n_tests++;
        if (done_seen !== 0 || HI !== prev_hi || LO !== prev_lo) begin
            n_fail++;
            $display("FAIL flush_no_result: got done count %0d HI=%h LO=%h, required 0 %h %h",
                     done_seen, HI, LO, prev_hi, prev_lo);
        end
        run_md(3'd0, 32'd6, 32'd7, bn, dn, da);
        n_tests++;
        if (HI !== 32'd0 || LO !== 32'd42 || dn !== 1) begin
            n_fail++;
            $display("FAIL restart_mult: got HI=%h LO=%h done=%0d, required 00000000 0000002a 1",
                     HI, LO, dn);
        end
    endtask

    task automatic test_random;
        logic [31:0] pool [6];
        logic [31:0] exp_hi, exp_lo, a, b;
        logic [2:0]  o;
        int bn, dn, da;
        pool[0] = 32'h0;
        pool[1] = 32'h1;
        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000;
        pool[4] = 32'h7FFF_FFFF;
        pool[5] = 32'hFFFF_FFFE;
        exp_hi = HI;
        exp_lo = LO;
        for (int t = 0; t < 40; t++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 31);
            if (!o[2]) begin
                ref_md(o, a, b, exp_hi, exp_lo);
                run_md(o, a, b, bn, dn, da);
                n_tests++;
                if (dn !== 1 || da !== W + 1) begin
                    n_fail++;
                    $display("FAIL rand_done_%0d: got count %0d at %0d, required 1 at %0d",
                             t, dn, da, W + 1);
                end
            end else begin
                if (o == 3'd4) exp_hi = a;
                if (o == 3'd5) exp_lo = a;
                @(negedge CLK);
                start = 1'b1; op = o; rs_val = a; rt_val = b;
                @(negedge CLK);
                start = 1'b0;
            end
            n_tests++;
            if (HI !== exp_hi || LO !== exp_lo) begin
                n_fail++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h: got HI=%h LO=%h, required %h %h",
                         t, o, a, b, HI, LO, exp_hi, exp_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_timing();
        test_multu_divu();
        test_div_signed();
        test_div_zero();
        test_mthi_mtlo();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
